// File: rtl/inst_cache_refill.sv
// inst_cache_refill: fetches a missing I-cache line as one 8-beat AXI burst,
// forwards the critical word early, then writes the whole line into the data RAM.
module inst_cache_refill #(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 5,
    parameter int BANK_NUM     = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req_valid,
    input  logic [31:0]            req_addr,
    output logic                   req_ready,
    output logic                   arvalid,
    output logic [31:0]            araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    input  logic                   arready,
    input  logic                   rvalid,
    input  logic [31:0]            rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    output logic                   rready,
    output logic                   ram_en,
    output logic [31:0]            ram_wen,
    output logic [INDEX_WIDTH-1:0] ram_index,
    output logic [32*BANK_NUM-1:0] ram_wdata,
    output logic                   crit_valid,
    output logic [31:0]            crit_data,
    output logic                   refill_done,
    output logic                   refill_err
);
    localparam int CW = $clog2(BANK_NUM);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_WIDTH) - 32'd1);

    typedef enum logic [1:0] {IDLE, AR, R, WR} state_t;

    state_t                  r_state, w_next;
    logic [31:0]             r_addr;
    logic [CW-1:0]           r_beat_cnt;
    logic [32*BANK_NUM-1:0]  r_line;
    logic                    r_crit_valid;
    logic [31:0]             r_crit_data;
    logic                    r_err;
    logic                    w_accept, w_beat, w_last_beat;

    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_beat      = (r_state == R) && rvalid;
    assign w_last_beat = r_beat_cnt == CW'(BANK_NUM - 1);

    assign araddr      = r_addr & LINE_MASK;
    assign arlen       = 8'(BANK_NUM - 1);
    assign arsize      = 3'b010;
    assign arburst     = 2'b01;
    assign ram_index   = r_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign ram_wdata   = r_line;
    assign crit_valid  = r_crit_valid;
    assign crit_data   = r_crit_data;
    assign refill_err  = r_err;

    always_comb begin
        w_next      = r_state;
        req_ready   = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        ram_en      = 1'b0;
        ram_wen     = '0;
        refill_done = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = AR;
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) w_next = R;
            end
            R: begin
                rready = 1'b1;
                if (rvalid && w_last_beat) w_next = WR;
            end
            WR: begin
                ram_en      = 1'b1;
                ram_wen     = '1;
                refill_done = 1'b1;
                w_next      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_beat_cnt   <= '0;
            r_line       <= '0;
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_crit_valid <= 1'b0;
            if (w_accept) begin
                r_addr     <= req_addr;
                r_beat_cnt <= '0;
                r_err      <= 1'b0;
            end
            if (w_beat) begin
                // word k lands in the MSB-first slot so bank 0 sits at the top of the line
                r_line[32*(BANK_NUM-1-int'(r_beat_cnt)) +: 32] <= rdata;
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (r_beat_cnt == r_addr[OFFSET_WIDTH-1:2]) begin
                    r_crit_valid <= 1'b1;
                    r_crit_data  <= rdata;
                end
                // the fill length is fixed; a misplaced or missing rlast is only flagged
                if (rresp != 2'b00 || rlast != w_last_beat) r_err <= 1'b1;
            end
        end
    end
endmodule
